// File: rtl/backend_resp_pkg.sv
// Shared defaults, per-entry layout and stall-LFSR constants for backend_responder.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// entry_t is sized from the DEF_* widths; the top module's width parameters
// default to these same values.
package backend_resp_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LAT_W  = 4;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11: taps sit at bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] result;
    logic [DEF_LAT_W-1:0]  remaining;
  } entry_t;

endpackage

// File: rtl/backend_responder_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward from start, wrapping.
// Latency: purely combinational.
// Backpressure: none; a requester that loses simply keeps requesting.
//
// Ports: req (request vector), start (first index searched, i.e. one past the
// last grant), gnt (one-hot grant), idx (granted index), any (a grant was made).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/backend_responder.sv
// Backend responder: per-channel in-order latency FIFOs returning matured results on a shared CDB.
// Latency: uncontended result appears on cdb_* L+1 cycles after the accept edge (L = disp_lat).
// Backpressure: none upstream; dispatch into a full channel is dropped and latches ovf.
//
// Ports: clk, rst (async, active low); disp_valid/disp_tag/disp_result/disp_lat
// per-channel dispatch (channel c at slice c*W +: W); flush squashes everything
// in flight; ch_full per channel; cdb_valid/cdb_tag/cdb_data/cdb_ch registered
// broadcast (payload holds while idle); ovf sticky drop flag.
// Optional macro BACKEND_RESP_STALL_EN: LFSR-driven random grant stalls.
module backend_responder
  import backend_resp_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT_W  = DEF_LAT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         disp_valid,
  input  logic [NUM_CH*TAG_W-1:0]   disp_tag,
  input  logic [NUM_CH*DATA_W-1:0]  disp_result,
  input  logic [NUM_CH*LAT_W-1:0]   disp_lat,
  input  logic                      flush,
  output logic [NUM_CH-1:0]         ch_full,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [$clog2(NUM_CH)-1:0] cdb_ch,
  output logic                      ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_CH);

  entry_t            mem    [NUM_CH][DEPTH];
  logic [PW-1:0]     wr_ptr [NUM_CH];
  logic [PW-1:0]     rd_ptr [NUM_CH];
  logic [CW-1:0]     cnt    [NUM_CH];
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt_idx;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic              gnt_any;
  logic              drop;
  logic              stall;
  entry_t            gnt_ent;

  always_comb begin
    ch_full = '0;
    push    = '0;
    elig    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_full[c] = (cnt[c] == CW'(DEPTH));
      push[c]    = disp_valid[c] & (cnt[c] != CW'(DEPTH)) & ~flush;
      elig[c]    = (cnt[c] != '0) && (mem[c][rd_ptr[c]].remaining == '0);
    end
  end

  // Fullness is judged on the pre-edge occupancy, so a same-cycle pop does not
  // rescue a dispatch into a full channel. Flush drops dispatches silently.
  assign drop    = (|(disp_valid & ch_full)) & ~flush;
  assign req     = elig & {NUM_CH{~(flush | stall)}};
  assign gnt_ent = mem[gnt_idx][rd_ptr[gnt_idx]];

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req   (req),
    .start (rr_ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

`ifdef BACKEND_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Entry storage needs no reset: occupancy alone decides what is live.
  // Every slot counts down; stale slots are overwritten on the next push.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int d = 0; d < DEPTH; d++) begin
        if (push[c] && (wr_ptr[c] == PW'(d))) begin
          mem[c][d] <= '{tag:       disp_tag[c*TAG_W +: TAG_W],
                         result:    disp_result[c*DATA_W +: DATA_W],
                         remaining: disp_lat[c*LAT_W +: LAT_W]};
        end else if (mem[c][d].remaining != '0) begin
          mem[c][d].remaining <= mem[c][d].remaining - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]    <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_ch    <= '0;
      ovf       <= 1'b0;
    end else begin
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_tag  <= gnt_ent.tag;
        cdb_data <= gnt_ent.result;
        cdb_ch   <= gnt_idx;
        rr_ptr   <= (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (drop) ovf <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          cnt[c]    <= '0;
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (gnt[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
          if (push[c] && !gnt[c])      cnt[c] <= cnt[c] + 1'b1;
          else if (!push[c] && gnt[c]) cnt[c] <= cnt[c] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_backend_responder.sv
// Testbench for backend_responder: directed dispatch vectors, scoreboard-checked CDB broadcasts.
// Latency: expected broadcast cycle is recorded per vector (ignored when grant stalls are enabled).
// Backpressure: drives overflow and flush cases and checks ch_full / ovf directly.
module tb_backend_responder;
  import backend_resp_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int LAT_W  = 4;
`ifdef BACKEND_RESP_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_CH-1:0]        disp_valid;
  logic [NUM_CH*TAG_W-1:0]  disp_tag;
  logic [NUM_CH*DATA_W-1:0] disp_result;
  logic [NUM_CH*LAT_W-1:0]  disp_lat;
  logic                     flush;
  logic [NUM_CH-1:0]        ch_full;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [1:0]               cdb_ch;
  logic                     ovf;

  backend_responder #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .LAT_W(LAT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_valid  (disp_valid),
    .disp_tag    (disp_tag),
    .disp_result (disp_result),
    .disp_lat    (disp_lat),
    .flush       (flush),
    .ch_full     (ch_full),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_ch      (cdb_ch),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          ch;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put(input int c, input int tag, input logic [31:0] data, input int lat);
    disp_valid[c]                   = 1'b1;
    disp_tag[c*TAG_W +: TAG_W]      = TAG_W'(tag);
    disp_result[c*DATA_W +: DATA_W] = data;
    disp_lat[c*LAT_W +: LAT_W]      = LAT_W'(lat);
  endtask

  task automatic expect_at(input int tag, input logic [31:0] data, input int c, input int cy);
    sb.push_back('{tag: tag, data: data, ch: c, cyc: (STALL ? -1 : cy)});
  endtask

  // Advance to the next falling edge and drop all one-cycle strobes.
  task automatic tick();
    @(negedge clk);
    disp_valid = '0;
    flush      = 1'b0;
  endtask

  // Monitor: every broadcast must match an outstanding expectation.
  initial begin : monitor
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (cdb_valid) begin
        vectors++;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && (!STALL || sb[i].data == cdb_data)) idx = i;
        if (idx < 0) begin
          miscompares++;
          $display("FAIL cdb_unexpected: got tag=%0d data=0x%0h ch=%0d at cycle %0d, want no broadcast",
                   cdb_tag, cdb_data, cdb_ch, cyc);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          if (int'(cdb_tag) != e.tag || cdb_data != e.data || int'(cdb_ch) != e.ch ||
              (e.cyc >= 0 && cyc != e.cyc)) begin
            miscompares++;
            $display("FAIL cdb_bcast: got tag=%0d data=0x%0h ch=%0d cycle=%0d, want tag=%0d data=0x%0h ch=%0d cycle=%0d",
                     cdb_tag, cdb_data, cdb_ch, cyc, e.tag, e.data, e.ch, e.cyc);
          end
        end
      end
    end
  end

  initial begin : stimulus
    disp_valid  = '0;
    disp_tag    = '0;
    disp_result = '0;
    disp_lat    = '0;
    flush       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst_cdb_data",  64'(cdb_data),  64'd0);
    chk("rst_cdb_ch",    64'(cdb_ch),    64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_ch_full",   64'(ch_full),   64'd0);
    rst = 1'b1;
    tick();

    // All four channels lat=0 at once: ch0..ch3 in consecutive cycles, twice.
    for (int rep = 0; rep < 2; rep++) begin
      k = cyc;
      for (int c = 0; c < NUM_CH; c++) begin
        put(c, rep * 10 + c + 1, 32'h100 + 32'(rep * 16 + c), 0);
        expect_at(rep * 10 + c + 1, 32'h100 + 32'(rep * 16 + c), c, k + 2 + c);
      end
      repeat (25) tick();
    end

    // Single dispatch ch0 tag 5 lat 3: broadcast 4 cycles after the accept edge.
    k = cyc;
    put(0, 5, 32'hDEAD, 3);
    expect_at(5, 32'hDEAD, 0, k + 5);
    repeat (25) tick();
    chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("hold_cdb_tag",   64'(cdb_tag),   64'd5);
    chk("hold_cdb_data",  64'(cdb_data),  64'hDEAD);

    // ch2: slow head (lat 7) blocks a ready follower (lat 0); back-to-back after it.
    k = cyc;
    put(2, 30, 32'h3030, 7);
    expect_at(30, 32'h3030, 2, k + 9);
    tick();
    put(2, 31, 32'h3131, 0);
    expect_at(31, 32'h3131, 2, k + 10);
    repeat (25) tick();
    chk("hol_cdb_ch", 64'(cdb_ch), 64'd2);

    // Flush with 6 in flight (ch3 full, one about to be granted), plus dispatches
    // in the flush cycle, one into the full channel: nothing comes out, ovf stays 0.
    put(3, 40, 32'h4000, 15);
    put(0, 41, 32'h4100, 15);
    tick();
    put(3, 42, 32'h4200, 15);
    tick();
    put(3, 43, 32'h4300, 15);
    tick();
    put(3, 44, 32'h4400, 15);
    put(2, 45, 32'h4500, 0);
    tick();
    chk("pre_flush_ch_full", 64'(ch_full), 64'b1000);
    flush = 1'b1;
    put(3, 46, 32'h4600, 0);
    put(0, 47, 32'h4700, 0);
    tick();
    chk("flush_ch_full", 64'(ch_full), 64'd0);
    chk("flush_ovf",     64'(ovf),     64'd0);
    repeat (30) tick();
    chk("post_flush_ch_full", 64'(ch_full), 64'd0);

    // Overflow on ch1: 4 accepted, 5th dropped, exactly 4 broadcasts.
    k = cyc;
    for (int j = 0; j < 4; j++) begin
      put(1, 20 + j, 32'h2000 + 32'(j), 15);
      expect_at(20 + j, 32'h2000 + 32'(j), 1, k + j + 17);
      tick();
    end
    chk("ovf_ch_full",  64'(ch_full), 64'b0010);
    chk("ovf_pre_drop", 64'(ovf),     64'd0);
    put(1, 24, 32'h2004, 0);
    tick();
    chk("ovf_set",      64'(ovf),     64'd1);
    chk("ovf_ch_full2", 64'(ch_full), 64'b0010);
    repeat (45) tick();
    chk("ovf_drained_ch_full", 64'(ch_full), 64'd0);
    chk("ovf_sticky",          64'(ovf),     64'd1);

    // Reset mid-stream with 3 pending: outputs clear, nothing broadcasts afterwards.
    put(0, 50, 32'h5000, 10);
    put(1, 51, 32'h5100, 10);
    put(2, 52, 32'h5200, 10);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("mid_rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("mid_rst_cdb_data",  64'(cdb_data),  64'd0);
    chk("mid_rst_cdb_ch",    64'(cdb_ch),    64'd0);
    chk("mid_rst_ovf",       64'(ovf),       64'd0);
    chk("mid_rst_ch_full",   64'(ch_full),   64'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (30) tick();
    k = cyc;
    put(1, 9, 32'h99, 2);
    expect_at(9, 32'h99, 1, k + 4);
    repeat (25) tick();

`ifdef BACKEND_RESP_STALL_EN
    // 100 lat=0 dispatches under random stalls: each must broadcast exactly once.
    for (int i = 0; i < 100; i++) begin
      put(i % NUM_CH, i % 64, 32'h7000 + 32'(i), 0);
      expect_at(i % 64, 32'h7000 + 32'(i), i % NUM_CH, -1);
      repeat (3) tick();
    end
    for (int n = 0; n < 3000 && sb.size() > 0; n++) tick();
    repeat (20) tick();
    chk("stall_ovf", 64'(ovf), 64'd0);
`endif

    chk("sb_outstanding", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/backend_responder.md
BACKEND_RESPONDER -- requirements
Module: backend_responder

Interface
REQ-001 Parameter NUM_CH, default 4: number of dispatch channels (int, mult, div, mem).
REQ-002 Parameter DEPTH, default 4: entries per channel; power of 2, at least 2.
REQ-003 Parameter TAG_W, default 6: ROB/physical tag width.
REQ-004 Parameter DATA_W, default 32: result width.
REQ-005 Parameter LAT_W, default 4: per-instruction latency field width.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Port disp_valid, input, NUM_CH: per-channel dispatch strobe.
REQ-009 Port disp_tag, input, NUM_CH*TAG_W: per-channel tag; channel c occupies slice [c*TAG_W +: TAG_W].
REQ-010 Port disp_result, input, NUM_CH*DATA_W: per-channel result value to return.
REQ-011 Port disp_lat, input, NUM_CH*LAT_W: per-channel execution latency in cycles.
REQ-012 Port flush, input, 1: squash all in-flight entries.
REQ-013 Port ch_full, output, NUM_CH: channel has DEPTH entries.
REQ-014 Port cdb_valid, output, 1: registered CDB broadcast.
REQ-015 Port cdb_tag, output, TAG_W: broadcast tag.
REQ-016 Port cdb_data, output, DATA_W: broadcast result.
REQ-017 Port cdb_ch, output, clog2(NUM_CH): source channel of the broadcast.
REQ-018 Port ovf, output, 1: sticky flag, set when a dispatch is dropped.

Function
REQ-019 Each channel SHALL be an in-order FIFO of DEPTH entries, each holding {tag, result, remaining}.
REQ-020 A dispatch SHALL be accepted when disp_valid[c]=1, ch_full[c]=0 and flush=0; accepting writes remaining=disp_lat.
REQ-021 A dispatch while ch_full[c]=1 SHALL be dropped and set ovf, even if the same channel pops in that cycle.
REQ-022 Every valid entry with remaining>0 SHALL decrement by 1 per cycle; remaining saturates at 0.
REQ-023 A channel head SHALL be eligible when valid and remaining=0; non-head entries never issue ahead of the head.
REQ-024 One eligible head per cycle SHALL be granted round-robin, searching upward from the channel after the last grant, wrapping at NUM_CH-1 to 0.
REQ-025 The granted head SHALL pop, and its tag, result and channel SHALL be registered onto the cdb_* outputs with cdb_valid=1 in the next cycle; otherwise cdb_valid=0.
REQ-026 Without contention, cdb_valid SHALL assert exactly L+1 cycles after the accept edge, where L=disp_lat.
REQ-027 A simultaneous push and pop on one channel SHALL both take effect; occupancy is unchanged.
REQ-028 Pointers SHALL wrap modulo DEPTH; ch_full SHALL be derived from an occupancy counter of width clog2(DEPTH)+1.
REQ-029 Flush SHALL clear all occupancies and pointers at that edge, suppress the grant that cycle (cdb_valid=0 next cycle) and drop same-cycle dispatches without setting ovf.
REQ-030 cdb_tag, cdb_data and cdb_ch SHALL hold their last values while cdb_valid=0.

Reset
REQ-031 On rst=0, all occupancies, pointers and the round-robin pointer SHALL be 0; cdb_valid, cdb_tag, cdb_data, cdb_ch, ovf and ch_full SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; no CDB broadcast follows deassertion until a new dispatch matures.

Configuration
REQ-033 Macro BACKEND_RESP_STALL_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) SHALL advance every cycle, and no grant SHALL occur in a cycle where LFSR bit 0=1; eligible entries wait and keep round-robin order.
REQ-034 When BACKEND_RESP_STALL_EN is undefined, no LFSR logic SHALL exist and grants SHALL never be suppressed except by flush.

Structure
REQ-035 Package backend_resp_pkg SHALL hold the parameter defaults, the entry struct typedef (tag, result, remaining) and the LFSR seed and taps constants.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs req and last-grant pointer; outputs one-hot grant and index).

Verification
REQ-037 Dispatch ch0 tag=5 result=32'hDEAD lat=3 -> cdb_valid 4 cycles later, tag 5, data 32'hDEAD, ch 0.
REQ-038 All four channels dispatch lat=0 in the same cycle, tags 1..4 -> four consecutive broadcasts in order ch0,1,2,3; the next simultaneous set starts at ch0 again.
REQ-039 Push 4 entries into ch1 (DEPTH=4), then a 5th -> ch_full[1]=1, 5th dropped, ovf=1, exactly 4 broadcasts.
REQ-040 Head lat=7 followed by next entry lat=0 on ch2 -> second entry broadcasts only after the head, in consecutive cycles.
REQ-041 Flush with 6 in-flight entries -> no broadcasts afterwards, ch_full=0, ovf unchanged.
REQ-042 Assert rst mid-stream with 3 pending -> all outputs 0; no broadcast after release; with BACKEND_RESP_STALL_EN defined, 100 lat=0 dispatches all eventually broadcast exactly once.
